// File: rtl/cdb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared types and sizing for the completion-side CDB arbiter.
//   DEF_NUM_FU / DEF_CDB_SZ : default functional-unit count and CDB width
//   BR_MASK                 : one bit per in-flight branch
//   BR_TASK                 : branch resolution command (NOTHING/CLEAR/SQUASH)
//   FU_PACKET               : result packet produced by a functional unit
//   brHit()                 : true when a packet depends on the resolving branch
// ---------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int DEF_NUM_FU = 4;
  localparam int DEF_CDB_SZ = 2;
  localparam int BR_W       = 4;

  typedef logic [BR_W-1:0] BR_MASK;

  typedef enum logic [1:0] {
    NOTHING = 2'd0,
    CLEAR   = 2'd1,
    SQUASH  = 2'd2
  } BR_TASK;

  typedef struct packed {
    logic [5:0] destPrf;
    BR_MASK     b_mask;
  } DECODED;

  typedef struct packed {
    logic [31:0] result;
    logic [5:0]  robIdx;
    DECODED      decoded_vals;
  } FU_PACKET;

  function automatic logic brHit(input BR_MASK mask, input BR_MASK brId);
    return |(mask & brId);
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_sel.sv
// ---------------------------------------------------------------------------
// cdb_rr_sel
// Combinational rotating-priority selector. Scans the request vector starting
// at rrPtr_i and wrapping modulo NUM_FU; the first CDB_SZ requesters found are
// granted, the k-th one on grant_o[k].
//   req_i     : live request per FU
//   rrPtr_i   : index where the scan starts
//   grant_o   : one one-hot (or zero) grant vector per CDB slot, in scan order
//   lastIdx_o : FU index of the last winner found by the scan
//   anyWin_o  : at least one grant was issued
// ---------------------------------------------------------------------------
module cdb_rr_sel
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = DEF_NUM_FU,
  parameter int CDB_SZ = DEF_CDB_SZ,
  parameter int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  parameter int SLOT_W = (CDB_SZ > 1) ? $clog2(CDB_SZ) : 1
) (
  input  logic [NUM_FU-1:0]             req_i,
  input  logic [PTR_W-1:0]              rrPtr_i,
  output logic [CDB_SZ-1:0][NUM_FU-1:0] grant_o,
  output logic [PTR_W-1:0]              lastIdx_o,
  output logic                          anyWin_o
);

  int winCount;
  int scanIdx;

  // Walk every FU once in rotated order. winCount doubles as the slot number
  // the next winner lands in, so slot order always follows scan order.
  always_comb begin
    grant_o   = '0;
    lastIdx_o = '0;
    anyWin_o  = 1'b0;
    winCount  = 0;
    scanIdx   = 0;
    for (int j = 0; j < NUM_FU; j++) begin
      scanIdx = int'(rrPtr_i) + j;
      if (scanIdx >= NUM_FU) scanIdx = scanIdx - NUM_FU;
      if (req_i[PTR_W'(scanIdx)] && (winCount < CDB_SZ)) begin
        grant_o[SLOT_W'(winCount)][PTR_W'(scanIdx)] = 1'b1;
        lastIdx_o = PTR_W'(scanIdx);
        anyWin_o  = 1'b1;
        winCount  = winCount + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Collects results from the functional units and broadcasts up to CDB_SZ of
// them per cycle on the common data bus. Losers are held with fu_stall.
// Branch resolution is applied both to incoming packets and to the packets
// sitting in the broadcast registers.
//   clock, reset : clock and synchronous active-high reset
//   fu_packs     : result packet from each FU
//   fu_ready     : per-FU packet valid
//   rem_br_task  : branch resolution command
//   rem_b_id     : one-hot branch being resolved
//   cdb_stall    : downstream cannot accept a broadcast next cycle
//   fu_stall     : per-FU stall back to the functional units
//   cdb_valid    : broadcast slot valid
//   cdb_packs    : registered broadcast packets
// ---------------------------------------------------------------------------
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = DEF_NUM_FU,
  parameter int CDB_SZ = DEF_CDB_SZ
) (
  input  logic                        clock,
  input  logic                        reset,
  input  FU_PACKET [NUM_FU-1:0]       fu_packs,
  input  logic     [NUM_FU-1:0]       fu_ready,
  input  BR_TASK                      rem_br_task,
  input  BR_MASK                      rem_b_id,
  input  logic                        cdb_stall,
  output logic     [NUM_FU-1:0]       fu_stall,
  output logic     [CDB_SZ-1:0]       cdb_valid,
  output FU_PACKET [CDB_SZ-1:0]       cdb_packs
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]              rrPtr_q, rrPtr_d;
  logic [CDB_SZ-1:0]             slotValid_q, slotValid_d;
  FU_PACKET [CDB_SZ-1:0]         slotPack_q, slotPack_d;

  logic [NUM_FU-1:0]             liveReq;
  logic [NUM_FU-1:0]             granted;
  logic [CDB_SZ-1:0][NUM_FU-1:0] grant;
  logic [PTR_W-1:0]              lastIdx;
  logic                          anyWin;

  // A packet that depends on the branch being squashed this cycle is not a
  // request at all: it is never granted and never stalled, so it drains out.
  always_comb begin
    liveReq = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      liveReq[i] = fu_ready[i] &&
                   !((rem_br_task == SQUASH) &&
                     brHit(fu_packs[i].decoded_vals.b_mask, rem_b_id));
    end
  end

  cdb_rr_sel #(
    .NUM_FU (NUM_FU),
    .CDB_SZ (CDB_SZ)
  ) uRrSel (
    .req_i     (liveReq),
    .rrPtr_i   (rrPtr_q),
    .grant_o   (grant),
    .lastIdx_o (lastIdx),
    .anyWin_o  (anyWin)
  );

  // Collapse the per-slot grants into one "this FU won" vector.
  always_comb begin
    granted = '0;
    for (int k = 0; k < CDB_SZ; k++) begin
      granted = granted | grant[k];
    end
  end

  // A downstream stall cancels every grant, so all live requesters hold.
  // Reset forces the stalls low so nothing upstream freezes during reset.
  always_comb begin
    fu_stall = '0;
    if (!reset) begin
      fu_stall = liveReq & (~granted | {NUM_FU{cdb_stall}});
    end
  end

  // Each slot either holds (downstream stall) or loads its winner; the branch
  // update is then applied to whichever value is about to be registered, so a
  // CLEAR arriving with a grant is folded into the freshly granted packet.
  always_comb begin
    slotValid_d = slotValid_q;
    slotPack_d  = slotPack_q;
    for (int k = 0; k < CDB_SZ; k++) begin
      if (!cdb_stall) begin
        slotValid_d[k] = |grant[k];
        slotPack_d[k]  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
          if (grant[k][i]) slotPack_d[k] = fu_packs[i];
        end
      end
      if (brHit(slotPack_d[k].decoded_vals.b_mask, rem_b_id)) begin
        if (rem_br_task == CLEAR) begin
          slotPack_d[k].decoded_vals.b_mask =
            slotPack_d[k].decoded_vals.b_mask & ~rem_b_id;
        end else if (rem_br_task == SQUASH) begin
          slotValid_d[k] = 1'b0;
          slotPack_d[k]  = '0;
        end
      end
    end
  end

  // Priority moves just past the last winner; with no winners it stays put.
  always_comb begin
    rrPtr_d = rrPtr_q;
    if (!cdb_stall && anyWin) begin
      if (lastIdx == PTR_W'(NUM_FU - 1)) rrPtr_d = '0;
      else                                rrPtr_d = lastIdx + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rrPtr_q     <= '0;
      slotValid_q <= '0;
      slotPack_q  <= '0;
    end else begin
      rrPtr_q     <= rrPtr_d;
      slotValid_q <= slotValid_d;
      slotPack_q  <= slotPack_d;
    end
  end

  assign cdb_valid = slotValid_q;
  assign cdb_packs = slotPack_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed scenarios followed by randomized traffic, all checked against a
// queue-based reference model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = DEF_NUM_FU;
  localparam int S = DEF_CDB_SZ;

  logic                clock;
  logic                reset;
  FU_PACKET [N-1:0]    fuPacks;
  logic     [N-1:0]    fuReady;
  BR_TASK              remTask;
  BR_MASK              remId;
  logic                cdbStall;
  logic     [N-1:0]    fuStall;
  logic     [S-1:0]    cdbValid;
  FU_PACKET [S-1:0]    cdbPacks;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state
  bit       mValid [S];
  FU_PACKET mPack  [S];
  int       mRr;
  logic [N-1:0] prevStall;
  logic [N-1:0] obsStall;

  cdb_arbiter #(
    .NUM_FU (N),
    .CDB_SZ (S)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .fu_packs    (fuPacks),
    .fu_ready    (fuReady),
    .rem_br_task (remTask),
    .rem_b_id    (remId),
    .cdb_stall   (cdbStall),
    .fu_stall    (fuStall),
    .cdb_valid   (cdbValid),
    .cdb_packs   (cdbPacks)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic FU_PACKET mkPack(input int res, input BR_MASK bm);
    FU_PACKET p;
    p = '0;
    p.result              = 32'(res);
    p.robIdx              = 6'(res);
    p.decoded_vals.b_mask = bm;
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one clock cycle with the inputs currently set, checking fu_stall
  // mid-cycle and the broadcast registers just after the edge.
  task automatic applyStimulus(input string tag);
    int           order[$];
    int           win[$];
    logic [N-1:0] live;
    logic [N-1:0] expStall;
    bit           nV [S];
    FU_PACKET     nP [S];
    int           nRr;
    bit           won;

    for (int i = 0; i < N; i++)
      live[i] = fuReady[i] && !(remTask == SQUASH &&
                (fuPacks[i].decoded_vals.b_mask & remId) != 0);
    for (int j = 0; j < N; j++)
      if (live[(mRr + j) % N]) order.push_back((mRr + j) % N);
    if (!cdbStall)
      for (int k = 0; k < S && k < order.size(); k++) win.push_back(order[k]);

    for (int i = 0; i < N; i++) begin
      won = 0;
      foreach (win[w]) if (win[w] == i) won = 1;
      expStall[i] = live[i] && (cdbStall || !won);
    end

    for (int k = 0; k < S; k++) begin
      if (cdbStall) begin
        nV[k] = mValid[k];
        nP[k] = mPack[k];
      end else begin
        nV[k] = (k < win.size());
        nP[k] = nV[k] ? fuPacks[win[k]] : '0;
      end
      if ((nP[k].decoded_vals.b_mask & remId) != 0) begin
        if (remTask == CLEAR)
          nP[k].decoded_vals.b_mask = nP[k].decoded_vals.b_mask & ~remId;
        else if (remTask == SQUASH) begin
          nV[k] = 0;
          nP[k] = '0;
        end
      end
    end
    nRr = (!cdbStall && win.size() > 0) ? (win[win.size()-1] + 1) % N : mRr;

    if (reset) begin
      expStall = '0;
      for (int k = 0; k < S; k++) begin
        nV[k] = 0;
        nP[k] = '0;
      end
      nRr = 0;
    end

    #3;
    obsStall = fuStall;
    checkOutput({tag, ":fu_stall"}, 64'(fuStall), 64'(expStall));
    prevStall = expStall;

    @(posedge clock);
    #1;
    for (int k = 0; k < S; k++) begin
      mValid[k] = nV[k];
      mPack[k]  = nP[k];
    end
    mRr = nRr;
    checkOutputs(tag);
  endtask

  task automatic checkOutputs(input string tag);
    for (int k = 0; k < S; k++) begin
      checkOutput($sformatf("%s:valid%0d", tag, k), 64'(cdbValid[k]), 64'(mValid[k]));
      checkOutput($sformatf("%s:pack%0d", tag, k), 64'(cdbPacks[k]), 64'(mPack[k]));
    end
  endtask

  initial begin
    int r;
    reset     = 1'b1;
    fuReady   = '0;
    fuPacks   = '0;
    remTask   = NOTHING;
    remId     = '0;
    cdbStall  = 1'b0;
    prevStall = '0;
    mRr       = 0;
    for (int k = 0; k < S; k++) begin
      mValid[k] = 0;
      mPack[k]  = '0;
    end
    @(posedge clock);
    #1;

    // Reset with everyone requesting: stalls forced low, slots empty
    fuReady = 4'b1111;
    for (int i = 0; i < N; i++) fuPacks[i] = mkPack(90 + i, '0);
    applyStimulus("reset0");
    applyStimulus("reset1");
    checkOutput("reset:valid", 64'(cdbValid), 64'd0);

    // Single request from the mult unit
    reset   = 1'b0;
    fuReady = 4'b0100;
    fuPacks = '0;
    fuPacks[2] = mkPack(6, '0);
    applyStimulus("single");
    checkOutput("single:stall", 64'(obsStall), 64'd0);
    checkOutput("single:valid0", 64'(cdbValid[0]), 64'd1);
    checkOutput("single:result0", 64'(cdbPacks[0].result), 64'd6);

    // Pointer now 3: FU3 must beat FU0 for slot 0
    fuReady = 4'b1001;
    fuPacks[2] = '0;
    fuPacks[0] = mkPack(10, '0);
    fuPacks[3] = mkPack(13, '0);
    applyStimulus("rrptr3");
    checkOutput("rrptr3:result0", 64'(cdbPacks[0].result), 64'd13);
    checkOutput("rrptr3:result1", 64'(cdbPacks[1].result), 64'd10);

    // Contention from a fresh pointer
    fuReady = '0;
    reset   = 1'b1;
    applyStimulus("rst2");
    reset   = 1'b0;
    fuReady = 4'b1111;
    for (int i = 0; i < N; i++) fuPacks[i] = mkPack(20 + i, '0);
    applyStimulus("cont1");
    checkOutput("cont1:stall", 64'(obsStall), 64'b1100);
    checkOutput("cont1:result0", 64'(cdbPacks[0].result), 64'd20);
    checkOutput("cont1:result1", 64'(cdbPacks[1].result), 64'd21);
    fuReady = 4'b1100;
    applyStimulus("cont2");
    checkOutput("cont2:stall", 64'(obsStall), 64'd0);
    checkOutput("cont2:result0", 64'(cdbPacks[0].result), 64'd22);
    checkOutput("cont2:result1", 64'(cdbPacks[1].result), 64'd23);

    // Downstream stall holds everything for three cycles
    fuReady = 4'b0011;
    fuPacks[0] = mkPack(30, '0);
    fuPacks[1] = mkPack(31, '0);
    cdbStall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus($sformatf("cstall%0d", c));
      checkOutput("cstall:stall", 64'(obsStall), 64'b0011);
      checkOutput("cstall:result0", 64'(cdbPacks[0].result), 64'd22);
      checkOutput("cstall:result1", 64'(cdbPacks[1].result), 64'd23);
    end
    cdbStall = 1'b0;
    applyStimulus("unstall");
    checkOutput("unstall:result0", 64'(cdbPacks[0].result), 64'd30);
    checkOutput("unstall:result1", 64'(cdbPacks[1].result), 64'd31);

    // Incoming squash removes FU1 from arbitration
    fuReady = 4'b0110;
    fuPacks[1] = mkPack(41, 4'b0010);
    fuPacks[2] = mkPack(42, 4'b0000);
    remTask = SQUASH;
    remId   = 4'b0010;
    applyStimulus("insquash");
    checkOutput("insquash:stall", 64'(obsStall), 64'd0);
    checkOutput("insquash:valid", 64'(cdbValid), 64'b01);
    checkOutput("insquash:result0", 64'(cdbPacks[0].result), 64'd42);

    // Registered clear then squash while the bus is stalled
    remTask = NOTHING;
    fuReady = 4'b1001;
    fuPacks[3] = mkPack(53, 4'b0011);
    fuPacks[0] = mkPack(50, 4'b0100);
    applyStimulus("regload");
    fuReady  = '0;
    cdbStall = 1'b1;
    remTask  = CLEAR;
    remId    = 4'b0001;
    applyStimulus("regclear");
    checkOutput("regclear:bmask0", 64'(cdbPacks[0].decoded_vals.b_mask), 64'b0010);
    checkOutput("regclear:valid", 64'(cdbValid), 64'b11);
    remTask = SQUASH;
    remId   = 4'b0100;
    applyStimulus("regsquash");
    checkOutput("regsquash:valid", 64'(cdbValid), 64'b01);
    checkOutput("regsquash:pack1", 64'(cdbPacks[1]), 64'd0);
    checkOutput("regsquash:bmask0", 64'(cdbPacks[0].decoded_vals.b_mask), 64'b0010);

    // Reset in the middle of traffic
    cdbStall = 1'b0;
    remTask  = NOTHING;
    remId    = '0;
    fuReady  = 4'b0011;
    fuPacks[0] = mkPack(60, '0);
    fuPacks[1] = mkPack(61, '0);
    applyStimulus("prerst");
    checkOutput("prerst:valid", 64'(cdbValid), 64'b11);
    fuReady = 4'b1111;
    reset   = 1'b1;
    applyStimulus("midrst");
    checkOutput("midrst:stall", 64'(obsStall), 64'd0);
    checkOutput("midrst:valid", 64'(cdbValid), 64'd0);
    reset   = 1'b0;
    fuReady = 4'b1001;
    fuPacks[0] = mkPack(70, '0);
    fuPacks[3] = mkPack(73, '0);
    applyStimulus("postrst");
    checkOutput("postrst:result0", 64'(cdbPacks[0].result), 64'd70);

    // Random traffic; stalled FUs keep their packet as the FU contract requires
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!prevStall[i]) begin
          fuReady[i] = ($urandom_range(0, 9) < 7);
          fuPacks[i] = mkPack(int'($urandom),
                              ($urandom_range(0, 1) == 0) ? BR_MASK'(0) : BR_MASK'($urandom));
        end
      end
      r = int'($urandom_range(0, 9));
      remTask  = (r < 7) ? NOTHING : ((r < 9) ? CLEAR : SQUASH);
      remId    = BR_MASK'(1 << $urandom_range(0, 3));
      cdbStall = ($urandom_range(0, 4) == 0);
      reset    = ($urandom_range(0, 49) == 0);
      applyStimulus("rand");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Completion-side arbiter that receives results from all functional units (ALU, mult, load, branch) over the `fu_pack` / `data_ready` / `stall` handshake and broadcasts up to `CDB_SZ` of them per cycle on the common data bus. It sits between the FU bank and the complete stage (ROB / map table / RS wakeup). FUs not granted are held via `stall`. Branch resolution is applied to both incoming and registered results.

## Interface
- `NUM_FU`, default 4: number of functional units feeding the arbiter.
- `CDB_SZ`, default 2: CDB broadcast ports per cycle (1 ≤ `CDB_SZ` ≤ `NUM_FU`).
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `fu_packs`  in  `NUM_FU` x FU_PACKET  result packet from each FU.
- `fu_ready`  in  `NUM_FU`  per-FU `data_ready`; packet valid this cycle.
- `rem_br_task`  in  BR_TASK  NOTHING / CLEAR / SQUASH from branch resolution.
- `rem_b_id`  in  BR_MASK  one-hot branch being resolved.
- `cdb_stall`  in  1  downstream cannot accept a broadcast next cycle.
- `fu_stall`  out  `NUM_FU`  per-FU stall; drives each FU's `stall` input.
- `cdb_valid`  out  `CDB_SZ`  broadcast slot valid.
- `cdb_packs`  out  `CDB_SZ` x FU_PACKET  registered broadcast packets.

## Operation
- Live request: `req[i] = fu_ready[i] && !(rem_br_task==SQUASH && (fu_packs[i].decoded_vals.b_mask & rem_b_id) != 0)`.
- Round-robin pick: scan from `rr_ptr` upward mod `NUM_FU`. The first `CDB_SZ` live requesters win. Winner k fills slot k in scan order.
- `fu_stall[i] = req[i] && (!granted[i] || cdb_stall)`. Non-requesters and squashed requesters always see 0, so squashed packets drain out of the FU.
- No `cdb_stall`: slot registers load the winners. Unused slots load `cdb_valid=0` and `cdb_packs='0`. `rr_ptr` ← (index of last winner + 1) mod `NUM_FU`. If there are no winners, `rr_ptr` holds.
- `cdb_stall`=1: slot registers and `rr_ptr` hold. No grants are issued.
- Branch update applied to the value entering each slot register, whether a new winner or a held entry:
  - CLEAR: if `b_mask & rem_b_id` is nonzero, clear that bit.
  - SQUASH: if `b_mask & rem_b_id` is nonzero, set `cdb_valid`=0 and `cdb_packs`='0.
- A CLEAR that coincides with a grant is applied to the granted packet before it is registered.
- Invariant: at most one slot holds a given FU's packet. A granted FU advances exactly once per grant.

## Timing
- Reset (sync): `cdb_valid`=0, `cdb_packs`='0, `rr_ptr`=0.
- While `reset` is high, `fu_stall`=0 (combinationally forced).
- Reset asserted mid-operation discards every registered broadcast at the next edge.
- Latency: a packet granted in cycle N appears on `cdb_packs` / `cdb_valid` in cycle N+1.
- `fu_stall` is combinational from `fu_ready`, `fu_packs`, `rem_*`, `cdb_stall` and `rr_ptr`. There is no path from `fu_stall` back to those inputs.
- FU contract: while `fu_stall[i]`=1, FU i presents the same packet next cycle.
- Every live request is granted within ⌈`NUM_FU`/`CDB_SZ`⌉ non-stalled cycles (starvation bound).
- All FUs requesting with `CDB_SZ`=`NUM_FU`: all are granted and no FU stalls.

## Structure
- FU_PACKET, BR_TASK and BR_MASK already live in `sys_defs.svh`.
- Add `` `NUM_FU `` and `` `CDB_SZ `` defines there. Do not hard-code these values in the module.
- Sub-module `cdb_rr_sel`: combinational rotating priority selector.
  - Inputs: `req`, `rr_ptr`.
  - Outputs: up to `CDB_SZ` one-hot grants in scan order, plus the last-winner index.
- `cdb_arbiter` owns `rr_ptr`, the slot registers, the branch-mask update and the `fu_stall` logic.

## Test plan
- Single request: reset, then `fu_ready`=0100 with mult result `0x0000_0006` → cycle+1: `cdb_valid[0]`=1, `cdb_packs[0].result`=6, `fu_stall`=0000, `rr_ptr`=3.
- Contention (`NUM_FU`=4, `CDB_SZ`=2): `fu_ready`=1111, `rr_ptr`=0.
  - Cycle 1: grants FU0 and FU1, `fu_stall`=1100, `rr_ptr`→2.
  - Cycle 2: grants FU2 and FU3, `fu_stall`=0000.
- `cdb_stall`: two slots valid, assert `cdb_stall` for 3 cycles with `fu_ready`=0011 → `cdb_packs` unchanged, `fu_stall`=0011, `rr_ptr` unchanged. Deassert → FU0 and FU1 broadcast next cycle.
- Incoming squash: FU1 ready with b_mask=0010; SQUASH with `rem_b_id`=0010 → FU1 not granted, `fu_stall[1]`=0. FU2 (b_mask=0000) takes slot 0.
- Registered clear/squash: slot 0 b_mask=0011, slot 1 b_mask=0100, `cdb_stall`=1.
  - CLEAR 0001 → slot 0 b_mask=0010.
  - Then SQUASH 0100 → `cdb_valid[1]`=0, `cdb_packs[1]`='0.
- Reset mid-stream: `cdb_valid`=11, assert `reset` for 1 cycle → `cdb_valid`=00, `rr_ptr`=0, `fu_stall`=0000 during reset.
